// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 receive path.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int START_BIT  = 0;
  localparam int PAR_BIT    = 9;
  localparam int STOP_BIT   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/ps2_fifo.sv
// Generic synchronous FIFO; head word reads as zero while empty.
module ps2_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic                  do_push, do_pop;

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    rdata   = empty ? '0 : mem[rp];
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pad sync, glitch filter, frame FSM, timeout, FIFO.
//
//  state | meaning
//  IDLE  | waiting for the start-bit clock fall
//  RECV  | collecting bits 1..10, stall timer running
//  CHECK | one cycle: validate start/parity/stop, push or flag
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int FILT       = 4,
  parameter int TIMEOUT    = 25000,
  parameter int CHECK_PAR  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PS2C,
  input  logic                  PS2D,
  input  logic                  done,
  output logic                  rdy,
  output logic [7:0]            data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  shift,
  output logic                  perr,
  output logic                  ferr,
  output logic                  ovf,
  input  logic                  clr_err
);

  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]            c_sync, d_sync;
  logic [1:0]            raw, filt;
  logic [FW-1:0]         fcnt [2];
  logic                  ps2c_f, ps2d_f, c_prev;
  state_t                state, state_n;
  logic [FRAME_BITS-1:0] frame;
  logic [3:0]            bcnt;
  logic [TW-1:0]         tmr;
  logic                  push, full, empty;
  logic                  set_perr, set_ferr, set_ovf;
  logic                  start_ok, par_ok;

  assign raw    = {c_sync[1], d_sync[1]};
  assign ps2c_f = filt[1];
  assign ps2d_f = filt[0];
  assign rdy    = ~empty;

  // Two-flop synchronisers; pads idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], PS2C};
      d_sync <= {d_sync[0], PS2D};
    end
  end

  // Filtered level follows the synchronised pin only after FILT differing samples in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILT - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered pulse on each filtered PS2C falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_prev <= 1'b1;
      shift  <= 1'b0;
    end else begin
      c_prev <= ps2c_f;
      shift  <= c_prev & ~ps2c_f;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, frame validation and flag/push requests.
  always_comb begin
    state_n  = state;
    push     = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    set_ovf  = 1'b0;
    start_ok = (frame[START_BIT] == 1'b0) && (frame[STOP_BIT] == 1'b1);
    par_ok   = (CHECK_PAR == 0) || (^frame[PAR_BIT:1] == 1'b1);
    case (state)
      IDLE: if (shift) state_n = RECV;
      RECV: begin
        if (shift && bcnt == 4'd10) begin
          state_n = CHECK;
        end else if (!shift && tmr == '0) begin
          set_ferr = 1'b1;
          state_n  = IDLE;
        end
      end
      CHECK: begin
        if (!start_ok)   set_ferr = 1'b1;
        else if (!par_ok) set_perr = 1'b1;
        else begin
          push    = 1'b1;
          set_ovf = full & ~done;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Frame capture, bit counter and stall down-counter (reloaded on every clock fall).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame <= '0;
      bcnt  <= '0;
      tmr   <= '0;
    end else begin
      case (state)
        IDLE: if (shift) begin
          frame    <= '0;
          frame[0] <= ps2d_f;
          bcnt     <= 4'd1;
          tmr      <= TW'(TIMEOUT);
        end
        RECV: begin
          if (shift) begin
            frame[bcnt] <= ps2d_f;
            bcnt        <= bcnt + 4'd1;
            tmr         <= TW'(TIMEOUT);
          end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end
        end
        default: bcnt <= '0;
      endcase
    end
  end

  // Sticky error flags; clear has priority over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr <= 1'b0;
      ferr <= 1'b0;
      ovf  <= 1'b0;
    end else if (clr_err) begin
      perr <= 1'b0;
      ferr <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      perr <= perr | set_perr;
      ferr <= ferr | set_ferr;
      ovf  <= ovf  | set_ovf;
    end
  end

  ps2_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (frame[8:1]),
    .pop   (done),
    .rdata (data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: PS/2 frames driven on the pads, outputs checked on the falling clk edge.
module tb_ps2_rx;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_np = 1'b1;
  logic       PS2C = 1'b1;
  logic       PS2D = 1'b1;
  logic       done = 1'b0;
  logic       clr_err = 1'b0;
  logic       rdy, shift, perr, ferr, ovf;
  logic [7:0] data;
  logic [4:0] count;
  logic       np_rdy, np_shift, np_perr, np_ferr, np_ovf;
  logic [7:0] np_data;
  logic [4:0] np_count;

  int vectors = 0;
  int errs = 0;
  int nshift = 0;
  int n0;

  always #5 clk = ~clk;

  ps2_rx #(.DEPTH_LOG2(4), .FILT(4), .TIMEOUT(200), .CHECK_PAR(1)) dut (
    .clk(clk), .rst(rst), .PS2C(PS2C), .PS2D(PS2D), .done(done),
    .rdy(rdy), .data(data), .count(count), .shift(shift),
    .perr(perr), .ferr(ferr), .ovf(ovf), .clr_err(clr_err)
  );

  ps2_rx #(.DEPTH_LOG2(4), .FILT(4), .TIMEOUT(200), .CHECK_PAR(0)) dut_np (
    .clk(clk), .rst(rst_np), .PS2C(PS2C), .PS2D(PS2D), .done(1'b0),
    .rdy(np_rdy), .data(np_data), .count(np_count), .shift(np_shift),
    .perr(np_perr), .ferr(np_ferr), .ovf(np_ovf), .clr_err(1'b0)
  );

  always @(posedge clk) if (shift) nshift++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_v,
                            input int nbits, input logic glitch, input logic popsync);
    logic [10:0] f;
    logic seen;
    f = {stop_v, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2D = f[i];
      wait_cyc(HALF);
      PS2C = 1'b0;
      if (popsync && i == 10) begin
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          if (shift) seen = 1'b1;
        end
        check("stop shift seen", 32'(seen), 32'd1);
        @(negedge clk) done = 1'b1;
        @(negedge clk) done = 1'b0;
        wait_cyc(HALF);
      end else if (glitch && i == 3) begin
        wait_cyc(8); PS2C = 1'b1; wait_cyc(2); PS2C = 1'b0; wait_cyc(HALF - 10);
      end else begin
        wait_cyc(HALF);
      end
      PS2C = 1'b1;
      if (glitch && i == 3) begin
        wait_cyc(8); PS2C = 1'b0; wait_cyc(2); PS2C = 1'b1;
      end
    end
    PS2D = 1'b1;
    wait_cyc(30);
  endtask

  task automatic pop(input logic [7:0] exp);
    check("pop head", 32'(data), 32'(exp));
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    wait_cyc(3);
    rst = 1'b0;
    rst_np = 1'b0;
    wait_cyc(5);

    check("reset rdy", 32'(rdy), 32'd0);
    check("reset data", 32'(data), 32'h00);
    check("reset count", 32'(count), 32'd0);
    check("reset shift", 32'(shift), 32'd0);
    check("reset flags", 32'({perr, ferr, ovf}), 32'd0);

    n0 = nshift;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check("1C shifts", 32'(nshift - n0), 32'd11);
    check("1C rdy", 32'(rdy), 32'd1);
    check("1C count", 32'(count), 32'd1);
    pop(8'h1C);
    check("1C rdy after pop", 32'(rdy), 32'd0);
    check("1C data after pop", 32'(data), 32'h00);

    for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check("fill count", 32'(count), 32'd16);
    check("fill ovf", 32'(ovf), 32'd0);
    send_frame(8'h11, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check("ovf set", 32'(ovf), 32'd1);
    check("ovf count", 32'(count), 32'd16);
    for (int i = 1; i <= 16; i++) pop(8'(i));
    check("drained count", 32'(count), 32'd0);
    pulse_clr();
    check("ovf cleared", 32'(ovf), 32'd0);

    rst_np = 1'b1; @(negedge clk); rst_np = 1'b0; @(negedge clk);
    send_frame(8'hAA, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    check("badpar count", 32'(count), 32'd0);
    check("badpar perr", 32'(perr), 32'd1);
    check("badpar ferr", 32'(ferr), 32'd0);
    check("nopar count", 32'(np_count), 32'd1);
    check("nopar data", 32'(np_data), 32'hAA);
    check("nopar perr", 32'(np_perr), 32'd0);
    pulse_clr();
    check("perr cleared", 32'(perr), 32'd0);

    send_frame(8'h33, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    check("badstop ferr", 32'(ferr), 32'd1);
    check("badstop count", 32'(count), 32'd0);
    check("badstop perr", 32'(perr), 32'd0);
    pulse_clr();

    send_frame(8'h77, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    check("stall ferr early", 32'(ferr), 32'd0);
    wait_cyc(260);
    check("timeout ferr", 32'(ferr), 32'd1);
    check("timeout count", 32'(count), 32'd0);
    pulse_clr();
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check("after timeout count", 32'(count), 32'd1);
    check("after timeout ferr", 32'(ferr), 32'd0);
    pop(8'h5A);

    n0 = nshift;
    send_frame(8'h3C, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    check("glitch shifts", 32'(nshift - n0), 32'd11);
    check("glitch count", 32'(count), 32'd1);
    pop(8'h3C);

    send_frame(8'h21, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h42, 1'b0, 1'b1, 11, 1'b0, 1'b1);
    check("push+pop count", 32'(count), 32'd1);
    pop(8'h42);
    check("push+pop empty", 32'(count), 32'd0);

    send_frame(8'h77, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'h10, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    check("pre-rst count", 32'(count), 32'd1);
    check("pre-rst perr", 32'(perr), 32'd1);
    send_frame(8'h66, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    rst = 1'b1;
    wait_cyc(2);
    check("midrst rdy/shift", 32'({rdy, shift}), 32'd0);
    check("midrst data", 32'(data), 32'h00);
    check("midrst count", 32'(count), 32'd0);
    check("midrst flags", 32'({perr, ferr, ovf}), 32'd0);
    rst = 1'b0;
    wait_cyc(5);
    send_frame(8'h99, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check("resume count", 32'(count), 32'd1);
    check("resume ferr", 32'(ferr), 32'd0);
    pop(8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
